store_write_buffer: RTL

- Posted-store FIFO between the D-bus store path of the memory controller and main memory.
- Stores retire into the buffer in one cycle instead of stalling the pipeline for the main-memory write latency.
- Entries drain to memory in order when memory is free.
- Block fills requested by the cache-fill logic take priority, except when the fill block has pending stores; those entries drain first so the fill never reads stale data.
- Loads snoop the buffer and get forwarded data.

---
 rtl/store_write_buffer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// Posted-store write buffer: queues D-bus stores, drains them in order to main memory,
// yields to block fills and forwards buffered data to loads. Optional macro: WB_COALESCE_EN.
module store_write_buffer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4,
  parameter int BLK_LSB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              fill_grant,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT
  } state_t;

  state_t            state, state_d;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [WC_W-1:0]   wait_cnt;
  logic              push, pop, start_wr, conflict;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DATA_W > 0 ? DEPTH : 1];

  // Entries are scanned oldest to newest (offset k from head), so a later hit overrides an earlier one.
  logic [PTR_W-1:0] fidx, cidx;

  // NOTE: every always_comb output gets a default before the loop/case, otherwise a latch is inferred.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fidx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = head + PTR_W'(k);
      if (CNT_W'(k) < count && addr_mem[fidx] == rd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fidx];
      end
    end
  end

  always_comb begin
    conflict = 1'b0;
    cidx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cidx = head + PTR_W'(k);
      if (CNT_W'(k) < count &&
          addr_mem[cidx][ADDR_W-1:BLK_LSB] == fill_addr[ADDR_W-1:BLK_LSB])
        conflict = 1'b1;
    end
  end

`ifdef WB_COALESCE_EN
  logic             co_hit, coalesce;
  logic [PTR_W-1:0] co_idx, sidx;

  // The head cannot be merged into once its write has been launched.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    sidx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      sidx = head + PTR_W'(k);
      if (CNT_W'(k) < count && addr_mem[sidx] == st_addr &&
          !(k == 0 && state != S_IDLE)) begin
        co_hit = 1'b1;
        co_idx = sidx;
      end
    end
  end

  assign st_ready = (count != CNT_W'(DEPTH)) | co_hit;
  assign coalesce = st_valid & co_hit;
  assign push     = st_valid & st_ready & ~co_hit;
`else
  assign st_ready = (count != CNT_W'(DEPTH));
  assign push     = st_valid & st_ready;
`endif

  assign fill_grant = fill_req & (state == S_IDLE) & ~conflict;
  assign empty      = (count == '0) & (state == S_IDLE);

  always_comb begin
    state_d  = state;
    start_wr = 1'b0;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0 && (!fill_req || conflict)) begin
          state_d  = S_WRITE;
          start_wr = 1'b1;
        end
      end
      S_WRITE: state_d = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == '0) begin
          state_d = S_IDLE;
          pop     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // NOTE: the entry storage has no reset; validity is carried entirely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= st_addr;
      data_mem[tail] <= st_data;
    end
`ifdef WB_COALESCE_EN
    if (coalesce) data_mem[co_idx] <= st_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wait_cnt <= '0;
      mem_en   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (start_wr) begin
        mem_en   <= 1'b1;
        mem_wr   <= 1'b1;
        mem_addr <= addr_mem[head];
`ifdef WB_COALESCE_EN
        // A store merging into the head on the launch edge must reach memory too.
        mem_data <= (coalesce && co_idx == head) ? st_data : data_mem[head];
`else
        mem_data <= data_mem[head];
`endif
      end else if (state == S_WRITE) begin
        mem_en <= 1'b0;
        mem_wr <= 1'b0;
      end

      if (state == S_WRITE)
        wait_cnt <= WC_W'(MEM_LAT - 2);
      else if (state == S_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - WC_W'(1);
    end
  end

endmodule
